// File: rtl/tiger_sbox_sched.sv
// Tiger S-box lookup scheduler: issues eight lookups on four ROMs and XOR-reduces them.
// Optional round update (o_a = a - even, o_b = b + odd) under `TIGER_SCHED_ROUND_EN.
module tiger_sbox_sched #(
  parameter int ROM_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [63:0] i_c,
  output logic [7:0]  o_addr_a,
  output logic [7:0]  o_addr_b,
  output logic [7:0]  o_addr_c,
  output logic [7:0]  o_addr_d,
  input  logic [63:0] i_data_a,
  input  logic [63:0] i_data_b,
  input  logic [63:0] i_data_c,
  input  logic [63:0] i_data_d,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [63:0] o_even,
  output logic [63:0] o_odd
`ifdef TIGER_SCHED_ROUND_EN
  ,
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  output logic [63:0] o_a,
  output logic [63:0] o_b
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_O,
    WAIT,
    CAP_E,
    CAP_O,
    DONE
  } state_t;

  localparam logic [1:0] WAIT_LAST =
    2'((ROM_LAT > 1) ? (ROM_LAT - 2) : 0);

  state_t      state;
  state_t      nxt;
  logic [1:0]  cnt;
  logic [31:0] odd_q;
  logic [63:0] dsum;
  logic        accept;

`ifdef TIGER_SCHED_ROUND_EN
  logic [63:0] a_q;
  logic [63:0] b_q;
`endif

  assign accept = i_valid & o_ready;
  assign dsum   = i_data_a ^ i_data_b ^ i_data_c ^ i_data_d;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = ISSUE_O;
      ISSUE_O: nxt = (ROM_LAT > 1) ? WAIT : CAP_E;
      WAIT:    if (cnt == WAIT_LAST) nxt = CAP_E;
      CAP_E:   nxt = CAP_O;
      CAP_O:   nxt = DONE;
      DONE:    if (i_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Address issue, wait counting, result capture and handshake flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_addr_a <= '0;
      o_addr_b <= '0;
      o_addr_c <= '0;
      o_addr_d <= '0;
      o_even   <= '0;
      o_odd    <= '0;
      cnt      <= '0;
      odd_q    <= '0;
`ifdef TIGER_SCHED_ROUND_EN
      a_q      <= '0;
      b_q      <= '0;
      o_a      <= '0;
      o_b      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            o_addr_a <= i_c[7:0];
            o_addr_b <= i_c[23:16];
            o_addr_c <= i_c[39:32];
            o_addr_d <= i_c[55:48];
            odd_q    <= {i_c[63:56], i_c[47:40],
                         i_c[31:24], i_c[15:8]};
            o_ready  <= 1'b0;
`ifdef TIGER_SCHED_ROUND_EN
            a_q      <= i_a;
            b_q      <= i_b;
`endif
          end
        end
        ISSUE_O: begin
          o_addr_a <= odd_q[31:24];
          o_addr_b <= odd_q[23:16];
          o_addr_c <= odd_q[15:8];
          o_addr_d <= odd_q[7:0];
          cnt      <= '0;
        end
        WAIT: begin
          cnt <= cnt + 2'd1;
        end
        CAP_E: begin
          o_even <= dsum;
        end
        CAP_O: begin
          o_odd   <= dsum;
          o_valid <= 1'b1;
`ifdef TIGER_SCHED_ROUND_EN
          o_a     <= a_q - o_even;
          o_b     <= b_q + dsum;
`endif
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiger_sbox_sched.sv
// Bench for tiger_sbox_sched: stub ROMs, ROM_LAT=1 and ROM_LAT=3 instances.
// Table-driven sums plus stall, reset-abort and back-to-back spacing sequences.
module tb_tiger_sbox_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid1, ready1, valid2, ready2;
  logic [63:0] c1, c2;
  logic        o_ready1, o_valid1, o_ready2, o_valid2;
  logic [7:0]  aa1, ab1, ac1, ad1, aa2, ab2, ac2, ad2;
  logic [63:0] da1, db1, dc1, dd1, da2, db2, dc2, dd2;
  logic [63:0] even1, odd1, even2, odd2;
`ifdef TIGER_SCHED_ROUND_EN
  logic [63:0] a1, b1, oa1, ob1, a2, b2, oa2, ob2;
`endif

  int total = 0;
  int bad = 0;

  tiger_sbox_sched #(.ROM_LAT(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_valid(valid1), .o_ready(o_ready1), .i_c(c1),
    .o_addr_a(aa1), .o_addr_b(ab1), .o_addr_c(ac1), .o_addr_d(ad1),
    .i_data_a(da1), .i_data_b(db1), .i_data_c(dc1), .i_data_d(dd1),
    .o_valid(o_valid1), .i_ready(ready1),
    .o_even(even1), .o_odd(odd1)
`ifdef TIGER_SCHED_ROUND_EN
    , .i_a(a1), .i_b(b1), .o_a(oa1), .o_b(ob1)
`endif
  );

  tiger_sbox_sched #(.ROM_LAT(3)) dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_valid(valid2), .o_ready(o_ready2), .i_c(c2),
    .o_addr_a(aa2), .o_addr_b(ab2), .o_addr_c(ac2), .o_addr_d(ad2),
    .i_data_a(da2), .i_data_b(db2), .i_data_c(dc2), .i_data_d(dd2),
    .o_valid(o_valid2), .i_ready(ready2),
    .o_even(even2), .o_odd(odd2)
`ifdef TIGER_SCHED_ROUND_EN
    , .i_a(a2), .i_b(b2), .o_a(oa2), .o_b(ob2)
`endif
  );

  // Single-register stub ROMs for the ROM_LAT=1 instance
  always @(posedge clk) begin
    da1 <= {56'h0, aa1};
    db1 <= {48'h0, ab1, 8'h0};
    dc1 <= {40'h0, ac1, 16'h0};
    dd1 <= {32'h0, ad1, 24'h0};
  end

  // Three-stage stub ROMs for the ROM_LAT=3 instance
  logic [63:0] pa [3], pb [3], pc [3], pd [3];
  always @(posedge clk) begin
    pa[0] <= {56'h0, aa2};
    pb[0] <= {48'h0, ab2, 8'h0};
    pc[0] <= {40'h0, ac2, 16'h0};
    pd[0] <= {32'h0, ad2, 24'h0};
    for (int i = 1; i < 3; i++) begin
      pa[i] <= pa[i-1]; pb[i] <= pb[i-1];
      pc[i] <= pc[i-1]; pd[i] <= pd[i-1];
    end
  end
  assign da2 = pa[2];
  assign db2 = pb[2];
  assign dc2 = pc[2];
  assign dd2 = pd[2];

  typedef struct {
    logic [63:0] c;
    logic [63:0] even;
    logic [63:0] odd;
  } vec_t;

  localparam int NV = 5;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_req(input bit two, input logic [63:0] c,
                         input logic [63:0] ee, input logic [63:0] eo,
                         input int elat, input string nm);
    int n;
    n = 0;
    while (!(two ? o_ready2 : o_ready1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready_to"}, 64'(n < 50), 64'd1);
    if (two) begin valid2 = 1'b1; c2 = c; end
    else     begin valid1 = 1'b1; c1 = c; end
    @(negedge clk);
    valid1 = 1'b0;
    valid2 = 1'b0;
    n = 0;
    while (!(two ? o_valid2 : o_valid1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(elat));
    chk({nm, " even"}, two ? even2 : even1, ee);
    chk({nm, " odd"}, two ? odd2 : odd1, eo);
    if (two) ready2 = 1'b1;
    else     ready1 = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
    ready2 = 1'b0;
    chk({nm, " valid_clr"}, 64'(two ? o_valid2 : o_valid1), 64'd0);
    chk({nm, " ready_set"}, 64'(two ? o_ready2 : o_ready1), 64'd1);
  endtask

  initial begin
    int n, acc, res, last, cyc;
    logic [63:0] se, so;

    vec[0] = '{64'h0706050403020100, 64'h06040200, 64'h01030507};
    vec[1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF};
    vec[2] = '{64'h0000000000000000, 64'h00000000, 64'h00000000};
    vec[3] = '{64'h1122334455667788, 64'h22446688, 64'h77553311};
    vec[4] = '{64'h0123456789ABCDEF, 64'h2367ABEF, 64'hCD894501};

    rst = 1'b1;
    valid1 = 1'b0; ready1 = 1'b0; c1 = '0;
    valid2 = 1'b0; ready2 = 1'b0; c2 = '0;
`ifdef TIGER_SCHED_ROUND_EN
    a1 = 64'h0; b1 = 64'hFFFFFFFFFFFFFFFF;
    a2 = 64'h0; b2 = 64'h0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst ready", 64'(o_ready1), 64'd1);
    chk("rst valid", 64'(o_valid1), 64'd0);
    chk("rst addr", {32'h0, aa1, ab1, ac1, ad1}, 64'h0);
    chk("rst even", even1, 64'h0);
    chk("rst odd", odd1, 64'h0);

    run_req(1'b0, vec[0].c, vec[0].even, vec[0].odd, 3, "first");
`ifdef TIGER_SCHED_ROUND_EN
    chk("round a", oa1, 64'hFFFFFFFFF9FBFE00);
    chk("round b", ob1, 64'h0000000001030506);
`endif

    for (int i = 0; i < NV; i++)
      run_req(1'b0, vec[i].c, vec[i].even, vec[i].odd, 3,
              $sformatf("lat1 v%0d", i));

    // Result stall with ignored request pulses
    valid1 = 1'b1; c1 = vec[0].c;
    @(negedge clk);
    valid1 = 1'b0;
    n = 0;
    while (!o_valid1 && n < 20) begin @(negedge clk); n++; end
    chk("stall latency", 64'(n), 64'd3);
    se = even1;
    so = odd1;
    for (int i = 0; i < 10; i++) begin
      valid1 = i[0];
      c1 = 64'h0123456789ABCDEF;
      @(negedge clk);
      chk("stall valid", 64'(o_valid1), 64'd1);
      chk("stall ready", 64'(o_ready1), 64'd0);
      chk("stall even", even1, 64'h06040200);
      chk("stall odd", odd1, 64'h01030507);
    end
    chk("stall even hold", even1, se);
    chk("stall odd hold", odd1, so);
    valid1 = 1'b0;
    ready1 = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no queued req", 64'(o_valid1), 64'd0);
      chk("idle ready", 64'(o_ready1), 64'd1);
    end

    // Reset while in CAP_E aborts the request
    valid1 = 1'b1; c1 = vec[3].c;
    @(negedge clk);
    valid1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort valid", 64'(o_valid1), 64'd0);
    chk("abort ready", 64'(o_ready1), 64'd1);
    chk("abort addr", {32'h0, aa1, ab1, ac1, ad1}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no result", 64'(o_valid1), 64'd0);
    end
    run_req(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF,
            3, "post_rst");

    // ROM_LAT=3 instance
    for (int i = 0; i < NV; i++)
      run_req(1'b1, vec[i].c, vec[i].even, vec[i].odd, 5,
              $sformatf("lat3 v%0d", i));

    // Back-to-back requests with the consumer always ready
    acc = 0; res = 0; last = -1;
    ready1 = 1'b1;
    for (cyc = 0; cyc < 200 && res < NV; cyc++) begin
      @(negedge clk);
      valid1 = (acc < NV);
      if (valid1) c1 = vec[acc].c;
      if (valid1 && o_ready1) begin
        if (acc > 0) chk("b2b spacing", 64'(cyc - last), 64'd5);
        last = cyc;
        acc++;
      end
      if (o_valid1) begin
        chk("b2b even", even1, vec[res].even);
        chk("b2b odd", odd1, vec[res].odd);
        res++;
      end
    end
    valid1 = 1'b0;
    ready1 = 1'b0;
    chk("b2b count", 64'(res), 64'(NV));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
